// File: rtl/cap_jump_sequencer.sv
// Control-flow sequencer between issue and the branch unit. Capability jumps are
// checked by the CLU first; one instruction in flight, one writeback each.
module cap_jump_sequencer #(
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned CLU_TIMEOUT   = 16,
  parameter bit          CHERI_EN      = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [1:0]               req_op_i,
  input  logic [TRANS_ID_BITS-1:0] req_trans_id_i,
  output logic                     clu_req_o,
  input  logic                     clu_done_i,
  input  logic                     clu_exc_i,
  output logic                     bu_valid_o,
  input  logic                     bu_exc_i,
  output logic                     wb_valid_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic                     wb_exc_o,
  output logic [1:0]               wb_exc_src_o,
  output logic                     busy_o
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StClu    = 2'd1;
  localparam logic [1:0] StBranch = 2'd2;
  localparam logic [1:0] StWb     = 2'd3;

  localparam logic [1:0] SrcNone    = 2'd0;
  localparam logic [1:0] SrcBu      = 2'd1;
  localparam logic [1:0] SrcClu     = 2'd2;
  localparam logic [1:0] SrcTimeout = 2'd3;

  // Watchdog fires in the CLU cycle whose count of elapsed CLU cycles reaches the limit.
  localparam logic [7:0] TimeoutLast = 8'(CLU_TIMEOUT - 1);

  logic [1:0]               state_q, state_d;
  logic [TRANS_ID_BITS-1:0] id_q, id_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [1:0]               src_d;
  logic                     handshake;
  logic                     is_cap;

  logic                     clu_req_q;
  logic                     busy_q;
  logic                     wb_valid_q;
  logic                     wb_exc_q;
  logic [1:0]               wb_exc_src_q;
  logic [TRANS_ID_BITS-1:0] wb_trans_id_q;

  assign req_ready_o = (state_q == StIdle) && !flush_i;
  assign bu_valid_o  = (state_q == StBranch) && !flush_i;
  assign handshake   = req_valid_i && req_ready_o;
  assign is_cap      = CHERI_EN && ((req_op_i == 2'd1) || (req_op_i == 2'd2));

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cnt_d   = '0;
    src_d   = SrcNone;
    case (state_q)
      StIdle: begin
        if (handshake) begin
          id_d    = req_trans_id_i;
          state_d = is_cap ? StClu : StBranch;
        end
      end
      StClu: begin
        cnt_d = cnt_q + 8'd1;
        // A completion in the same cycle as the watchdog expiry takes precedence.
        if (clu_done_i) begin
          if (clu_exc_i) begin
            state_d = StWb;
            src_d   = SrcClu;
          end else begin
            state_d = StBranch;
          end
        end else if (cnt_q == TimeoutLast) begin
          state_d = StWb;
          src_d   = SrcTimeout;
        end
      end
      StBranch: begin
        state_d = StWb;
        src_d   = bu_exc_i ? SrcBu : SrcNone;
      end
      StWb: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (flush_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      id_q          <= '0;
      cnt_q         <= '0;
      clu_req_q     <= 1'b0;
      busy_q        <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_exc_q      <= 1'b0;
      wb_exc_src_q  <= SrcNone;
      wb_trans_id_q <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      clu_req_q  <= (state_d == StClu);
      busy_q     <= (state_d != StIdle);
      wb_valid_q <= (state_d == StWb);
      if (state_d == StWb) begin
        wb_exc_q      <= (src_d != SrcNone);
        wb_exc_src_q  <= src_d;
        wb_trans_id_q <= id_q;
      end else begin
        wb_exc_q     <= 1'b0;
        wb_exc_src_q <= SrcNone;
      end
    end
  end

  assign clu_req_o     = clu_req_q;
  assign busy_o        = busy_q;
  assign wb_valid_o    = wb_valid_q;
  assign wb_exc_o      = wb_exc_q;
  assign wb_exc_src_o  = wb_exc_src_q;
  assign wb_trans_id_o = wb_trans_id_q;

endmodule

// File: tb/tb_cap_jump_sequencer.sv
// Bench for cap_jump_sequencer: per-instruction expected timelines derived from the
// latency rules, checked every cycle for directed and random instructions.
module tb_cap_jump_sequencer;

  localparam int IDW = 3;
  localparam int TO  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic           req_valid = 1'b0;
  logic           nc_valid = 1'b0;
  logic [1:0]     req_op = 2'd0;
  logic [IDW-1:0] req_id = '0;
  logic           clu_done = 1'b0;
  logic           clu_exc = 1'b0;
  logic           bu_exc = 1'b0;

  logic           req_ready, clu_req, bu_valid, wb_valid, wb_exc, busy;
  logic [IDW-1:0] wb_id;
  logic [1:0]     wb_src;

  logic           nc_ready, nc_clu_req, nc_bu_valid, nc_wb_valid, nc_wb_exc, nc_busy;
  logic [IDW-1:0] nc_wb_id;
  logic [1:0]     nc_wb_src;

  int total = 0;
  int bad   = 0;

  cap_jump_sequencer #(
    .TRANS_ID_BITS(IDW),
    .CLU_TIMEOUT  (TO),
    .CHERI_EN     (1'b1)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_op_i      (req_op),
    .req_trans_id_i(req_id),
    .clu_req_o     (clu_req),
    .clu_done_i    (clu_done),
    .clu_exc_i     (clu_exc),
    .bu_valid_o    (bu_valid),
    .bu_exc_i      (bu_exc),
    .wb_valid_o    (wb_valid),
    .wb_trans_id_o (wb_id),
    .wb_exc_o      (wb_exc),
    .wb_exc_src_o  (wb_src),
    .busy_o        (busy)
  );

  cap_jump_sequencer #(
    .TRANS_ID_BITS(IDW),
    .CLU_TIMEOUT  (TO),
    .CHERI_EN     (1'b0)
  ) dut_nc (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .req_valid_i   (nc_valid),
    .req_ready_o   (nc_ready),
    .req_op_i      (req_op),
    .req_trans_id_i(req_id),
    .clu_req_o     (nc_clu_req),
    .clu_done_i    (clu_done),
    .clu_exc_i     (clu_exc),
    .bu_valid_o    (nc_bu_valid),
    .bu_exc_i      (bu_exc),
    .wb_valid_o    (nc_wb_valid),
    .wb_trans_id_o (nc_wb_id),
    .wb_exc_o      (nc_wb_exc),
    .wb_exc_src_o  (nc_wb_src),
    .busy_o        (nc_busy)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle 0 is the handshake cycle. fpick=0: no flush; otherwise flush in cycle
  // 1 + (fpick-1) % wb_cycle, i.e. somewhere between the first busy cycle and writeback.
  task automatic transact(input logic [1:0] op, input logic [IDW-1:0] id, input int n_done,
                          input bit cexc, input bit bexc, input int fpick);
    bit cap, has_bu;
    int clu_len, bu_c, wb_c, src, f, fin;
    bit wb;
    cap    = (op == 2'd1) || (op == 2'd2);
    bu_c   = -1;
    has_bu = 1'b0;
    if (cap) begin
      if (n_done >= 1 && n_done <= TO) begin
        clu_len = n_done;
        if (cexc) begin
          wb_c = clu_len + 1;
          src  = 2;
        end else begin
          has_bu = 1'b1;
          bu_c   = clu_len + 1;
          wb_c   = clu_len + 2;
          src    = bexc ? 1 : 0;
        end
      end else begin
        clu_len = TO;
        wb_c    = TO + 1;
        src     = 3;
      end
    end else begin
      clu_len = 0;
      has_bu  = 1'b1;
      bu_c    = 1;
      wb_c    = 2;
      src     = bexc ? 1 : 0;
    end
    f   = (fpick > 0) ? 1 + (fpick - 1) % wb_c : 0;
    fin = (f >= 1 && f < wb_c) ? f : wb_c;

    for (int c = 0; c <= fin + 2; c++) begin
      @(negedge clk);
      req_valid = (c == 0);
      req_op    = (c == 0) ? op : 2'($urandom);
      req_id    = (c == 0) ? id : IDW'($urandom);
      clu_done  = (n_done >= 1) && (c == n_done);
      clu_exc   = clu_done ? cexc : 1'($urandom);
      bu_exc    = (has_bu && c == bu_c) ? bexc : 1'($urandom);
      flush     = (f >= 1) && (c == f);
      #1;
      wb = (c == wb_c) && (wb_c <= fin);
      chk("req_ready", 8'(req_ready), 8'(c == 0 || c > fin));
      chk("busy", 8'(busy), 8'(c >= 1 && c <= fin));
      chk("clu_req", 8'(clu_req), 8'(cap && c >= 1 && c <= clu_len && c <= fin));
      chk("bu_valid", 8'(bu_valid), 8'(has_bu && c == bu_c && c <= fin && c != f));
      chk("wb_valid", 8'(wb_valid), 8'(wb));
      if (wb) begin
        chk("wb_id", 8'(wb_id), 8'(id));
        chk("wb_exc", 8'(wb_exc), 8'(src != 0));
        chk("wb_src", 8'(wb_src), 8'(src));
      end
    end
    req_valid = 1'b0;
    flush     = 1'b0;
    clu_done  = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready", 8'(req_ready), 8'd1);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_clu_req", 8'(clu_req), 8'd0);
    chk("rst_bu_valid", 8'(bu_valid), 8'd0);
    chk("rst_wb_valid", 8'(wb_valid), 8'd0);
    chk("rst_wb_exc", 8'(wb_exc), 8'd0);
    chk("rst_wb_src", 8'(wb_src), 8'd0);
    chk("rst_wb_id", 8'(wb_id), 8'd0);
    rst = 1'b0;

    // Directed cases
    transact(2'd0, 3'd5, 0, 1'b0, 1'b0, 0);  // plain op
    transact(2'd1, 3'd2, 3, 1'b0, 1'b0, 0);  // CJALR clean, done after 3 CLU cycles
    transact(2'd2, 3'd6, 2, 1'b1, 1'b0, 0);  // CINVOKE with CLU exception
    transact(2'd1, 3'd3, 0, 1'b0, 1'b0, 0);  // watchdog timeout
    transact(2'd2, 3'd4, 6, 1'b0, 1'b0, 0);  // timeout, late done ignored
    transact(2'd1, 3'd1, TO, 1'b0, 1'b1, 0); // done coincides with timeout; bu exception
    transact(2'd0, 3'd7, 0, 1'b0, 1'b1, 1);  // flush in BRANCH
    transact(2'd3, 3'd0, 0, 1'b0, 1'b1, 0);  // reserved op takes plain path
    transact(2'd1, 3'd5, 2, 1'b0, 1'b0, 2);  // flush coincides with CLU done
    transact(2'd0, 3'd2, 0, 1'b0, 1'b0, 2);  // flush during WB still writes back

    // Reset mid-CLU
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'd2;
    req_id    = 3'd3;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("midclu_clu_req", 8'(clu_req), 8'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    clu_done = 1'b1;
    #1;
    chk("midrst_clu_req", 8'(clu_req), 8'd0);
    chk("midrst_busy", 8'(busy), 8'd0);
    chk("midrst_bu_valid", 8'(bu_valid), 8'd0);
    chk("midrst_wb_valid", 8'(wb_valid), 8'd0);
    chk("midrst_ready", 8'(req_ready), 8'd1);
    @(negedge clk);
    clu_done = 1'b0;
    #1;
    chk("midrst_stray_busy", 8'(busy), 8'd0);
    chk("midrst_stray_wb", 8'(wb_valid), 8'd0);

    // CHERI disabled: CJALR takes the plain path
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      nc_valid = (c == 0);
      req_op   = 2'd1;
      req_id   = 3'd6;
      bu_exc   = 1'b0;
      #1;
      chk("nc_clu_req", 8'(nc_clu_req), 8'd0);
      chk("nc_bu_valid", 8'(nc_bu_valid), 8'(c == 1));
      chk("nc_wb_valid", 8'(nc_wb_valid), 8'(c == 2));
      chk("nc_ready", 8'(nc_ready), 8'(c == 0 || c == 3));
      if (c == 2) begin
        chk("nc_wb_id", 8'(nc_wb_id), 8'd6);
        chk("nc_wb_exc", 8'(nc_wb_exc), 8'd0);
      end
    end
    nc_valid = 1'b0;

    // Random instructions
    for (int i = 0; i < 120; i++) begin
      transact(2'($urandom_range(0, 3)), IDW'($urandom), int'($urandom_range(0, TO + 2)),
               1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
